// File: rtl/sif_pkg.sv
// Shared types for the SIF initiator: FSM states and the queued command word.
package sif_pkg;

    localparam int unsigned SIF_AW = 16;
    localparam int unsigned SIF_DW = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RSP
    } sif_state_e;

    typedef struct packed {
        logic              wr;
        logic [SIF_AW-1:0] addr;
        logic [SIF_DW-1:0] wdata;
    } sif_cmd_t;

endpackage

// File: rtl/sif_cmd_fifo.sv
// Synchronous command FIFO; the extra pointer bit separates full from empty.
module sif_cmd_fifo
    import sif_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  sif_cmd_t din,
    output sif_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    sif_cmd_t    mem [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/sif_initiator.sv
// SIF bus initiator: queued commands, back-to-back writes, one read in flight.
module sif_initiator
    import sif_pkg::*;
#(
    parameter int unsigned AW         = SIF_AW,
    parameter int unsigned DW         = SIF_DW,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_rdata,
    output logic          xa_wr_s,
    output logic          xa_rd_s,
    output logic [AW-1:0] xa_addr,
    output logic [DW-1:0] xa_data_wr,
    input  logic [DW-1:0] xa_data_rd,
    output logic          busy,
    output logic [15:0]   wr_cnt,
    output logic [15:0]   rd_cnt
);

    sif_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ready_en;
    sif_cmd_t   cmd_in, head;
    logic       fifo_full, fifo_empty, fifo_pop;
    logic       can_issue, issue_wr, issue_rd, capture;

    assign cmd_in    = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = ready_en && !fifo_full;
    assign rsp_valid = (state_q == RSP);
    assign busy      = !fifo_empty || (state_q != IDLE);

    sif_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (fifo_pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The response handshake cycle dispatches like IDLE so its strobe lands the next cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fifo_pop  = 1'b0;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        capture   = 1'b0;
        can_issue = (state_q == IDLE) || ((state_q == RSP) && rsp_ready);

        if (state_q == RD_WAIT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                capture = 1'b1;
                state_d = RSP;
            end
        end
        if ((state_q == RSP) && rsp_ready) state_d = IDLE;

        if (can_issue && !fifo_empty) begin
            fifo_pop = 1'b1;
            if (head.wr) begin
                issue_wr = 1'b1;
            end else begin
                issue_rd = 1'b1;
                state_d  = RD_WAIT;
                cnt_d    = 3'(RD_LAT);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_en   <= 1'b0;
            xa_wr_s    <= 1'b0;
            xa_rd_s    <= 1'b0;
            xa_addr    <= '0;
            xa_data_wr <= '0;
            rsp_addr   <= '0;
            rsp_rdata  <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en   <= 1'b1;
            xa_wr_s    <= issue_wr;
            xa_rd_s    <= issue_rd;
            xa_addr    <= (issue_wr || issue_rd) ? head.addr : '0;
            xa_data_wr <= issue_wr ? head.wdata : '0;
            if (issue_rd) rsp_addr  <= head.addr;
            if (capture)  rsp_rdata <= xa_data_rd;
            if (issue_wr) wr_cnt    <= wr_cnt + 1'b1;
            if (issue_rd) rd_cnt    <= rd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sif_initiator.sv
// Directed bench for sif_initiator with a fixed-content responder (RD_LAT=1).
module tb_sif_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_addr, rsp_rdata;
    logic        xa_wr_s, xa_rd_s;
    logic [15:0] xa_addr, xa_data_wr;
    logic [15:0] xa_data_rd = '0;
    logic        busy;
    logic [15:0] wr_cnt, rd_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int viol     = 0;

    typedef struct {
        logic        is_wr;
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t evq[$];
    ev_t rspq[$];

    sif_initiator #(.AW(16), .DW(16), .FIFO_DEPTH(4), .RD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_addr   (rsp_addr),
        .rsp_rdata  (rsp_rdata),
        .xa_wr_s    (xa_wr_s),
        .xa_rd_s    (xa_rd_s),
        .xa_addr    (xa_addr),
        .xa_data_wr (xa_data_wr),
        .xa_data_rd (xa_data_rd),
        .busy       (busy),
        .wr_cnt     (wr_cnt),
        .rd_cnt     (rd_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h05DE: rom = 16'h04DE;
            16'h0463: rom = 16'h04E3;
            16'h1305: rom = 16'h1305;
            default:  rom = 16'hDEAD;
        endcase
    endfunction

    // Responder: read data valid the cycle after the strobe.
    always @(posedge clk) xa_data_rd <= xa_rd_s ? rom(xa_addr) : 16'h0000;

    always @(negedge clk) begin
        if (xa_wr_s || xa_rd_s) evq.push_back('{xa_wr_s, cyc, xa_addr, xa_data_wr});
        if (rsp_valid && rsp_ready) rspq.push_back('{1'b0, cyc, rsp_addr, rsp_rdata});
        if ((xa_wr_s && xa_rd_s) || (xa_rd_s && xa_data_wr != 16'h0) ||
            (!xa_wr_s && !xa_rd_s && (xa_addr != 16'h0 || xa_data_wr != 16'h0)))
            viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic wr, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("push_timeout", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 0);
        repeat (2) tick();
    endtask

    logic [15:0] s1_addr [3] = '{16'h05DE, 16'h0463, 16'h1305};
    logic [15:0] s1_data [3] = '{16'h04DE, 16'h04E3, 16'h1305};
    logic [15:0] s2_addr [4] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    logic [15:0] s2_data [4] = '{16'hAAAA, 16'h5555, 16'h1234, 16'hFFFF};

    initial begin
        int e0, r0, x, n;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_strobes", {30'h0, xa_wr_s, xa_rd_s}, 0);
        check("rst_xa_addr", 32'(xa_addr), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);
        check("post_rst_cnts", {wr_cnt, rd_cnt}, 0);

        // 1: three reads
        e0 = evq.size();
        r0 = rspq.size();
        for (int i = 0; i < 3; i++) push_cmd(1'b0, s1_addr[i], 16'h0);
        wait_idle();
        check("s1_nrsp", rspq.size() - r0, 3);
        check("s1_nev", evq.size() - e0, 3);
        for (int i = 0; i < 3; i++) begin
            check("s1_rsp_addr", 32'(rspq[r0+i].addr), 32'(s1_addr[i]));
            check("s1_rsp_data", 32'(rspq[r0+i].data), 32'(s1_data[i]));
            check("s1_is_rd", 32'(evq[e0+i].is_wr), 0);
        end
        for (int i = 1; i < 3; i++)
            check("s1_rd_spacing", evq[e0+i].cyc - evq[e0+i-1].cyc, 3);
        check("s1_rd_cnt", 32'(rd_cnt), 3);

        // 2: four back-to-back writes
        e0 = evq.size();
        r0 = rspq.size();
        for (int i = 0; i < 4; i++) push_cmd(1'b1, s2_addr[i], s2_data[i]);
        wait_idle();
        check("s2_nev", evq.size() - e0, 4);
        for (int i = 0; i < 4; i++) begin
            check("s2_is_wr", 32'(evq[e0+i].is_wr), 1);
            check("s2_addr", 32'(evq[e0+i].addr), 32'(s2_addr[i]));
            check("s2_data", 32'(evq[e0+i].data), 32'(s2_data[i]));
            if (i > 0) check("s2_consecutive", evq[e0+i].cyc - evq[e0+i-1].cyc, 1);
        end
        check("s2_wr_cnt", 32'(wr_cnt), 4);
        check("s2_rd_cnt", 32'(rd_cnt), 3);
        check("s2_no_rsp", rspq.size() - r0, 0);

        // 3: response back-pressure while the FIFO fills
        rsp_ready = 1'b0;
        push_cmd(1'b0, 16'h05DE, 16'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("s3_rsp_seen", 32'(rsp_valid), 1);
        e0 = evq.size();
        for (int i = 0; i < 5; i++) begin
            check("s3_rsp_valid_hold", 32'(rsp_valid), 1);
            check("s3_rsp_rdata_hold", 32'(rsp_rdata), 32'h04DE);
            if (i < 4) begin
                cmd_valid = 1'b1;
                cmd_wr    = 1'b1;
                cmd_addr  = 16'h0020 + 16'(i);
                cmd_wdata = 16'hA000 + 16'(i);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        check("s3_cmd_ready_full", 32'(cmd_ready), 0);
        check("s3_no_strobe", evq.size() - e0, 0);
        x = cyc;
        rsp_ready = 1'b1;
        tick();
        wait_idle();
        check("s3_nev", evq.size() - e0, 4);
        check("s3_first_strobe_cyc", evq[e0].cyc - x, 1);
        for (int i = 0; i < 4; i++) begin
            check("s3_addr", 32'(evq[e0+i].addr), 32'h0020 + i);
            check("s3_data", 32'(evq[e0+i].data), 32'hA000 + i);
        end
        check("s3_wr_cnt", 32'(wr_cnt), 8);

        // 4: write, read, write
        e0 = evq.size();
        r0 = rspq.size();
        push_cmd(1'b1, 16'h0100, 16'hBEEF);
        push_cmd(1'b0, 16'h0463, 16'h0);
        push_cmd(1'b1, 16'h0101, 16'hCAFE);
        wait_idle();
        check("s4_nev", evq.size() - e0, 3);
        check("s4_order", {29'h0, evq[e0].is_wr, evq[e0+1].is_wr, evq[e0+2].is_wr}, 3'b101);
        check("s4_w1", {evq[e0].addr, evq[e0].data}, 32'h0100BEEF);
        check("s4_r_addr", 32'(evq[e0+1].addr), 32'h0463);
        check("s4_w2", {evq[e0+2].addr, evq[e0+2].data}, 32'h0101CAFE);
        check("s4_rsp_data", 32'(rspq[r0].data), 32'h04E3);
        check("s4_w2_after_hs", evq[e0+2].cyc - rspq[r0].cyc, 1);
        check("s4_r_to_w2", evq[e0+2].cyc - evq[e0+1].cyc, 3);

        // 5: reset while a read is outstanding
        push_cmd(1'b0, 16'h1305, 16'h0);
        push_cmd(1'b1, 16'h0300, 16'h1111);
        n = 0;
        while (!xa_rd_s && n < 20) begin
            tick();
            n++;
        end
        check("s5_rd_strobe_seen", 32'(xa_rd_s), 1);
        tick();
        e0 = evq.size();
        r0 = rspq.size();
        #2;
        rst = 1'b1;
        #1;
        check("s5_async_strobes", {30'h0, xa_wr_s, xa_rd_s}, 0);
        check("s5_async_addr", 32'(xa_addr), 0);
        check("s5_async_rsp_valid", 32'(rsp_valid), 0);
        check("s5_async_busy", 32'(busy), 0);
        check("s5_async_cnts", {wr_cnt, rd_cnt}, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        check("s5_no_rsp", rspq.size() - r0, 0);
        check("s5_no_ev", evq.size() - e0, 0);
        check("s5_fifo_empty", 32'(busy), 0);
        push_cmd(1'b0, 16'h05DE, 16'h0);
        wait_idle();
        check("s5_nrsp", rspq.size() - r0, 1);
        check("s5_rsp", {rspq[r0].addr, rspq[r0].data}, 32'h05DE04DE);
        check("s5_cnts", {wr_cnt, rd_cnt}, 32'h00000001);

        // 6: write counter wrap
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 16'h0200;
        cmd_wdata = 16'h5A5A;
        repeat (65535) tick();
        cmd_valid = 1'b0;
        wait_idle();
        check("s6_wr_cnt_max", 32'(wr_cnt), 32'hFFFF);
        push_cmd(1'b1, 16'h0201, 16'h0001);
        wait_idle();
        check("s6_wr_cnt_wrap", 32'(wr_cnt), 0);
        check("s6_rd_cnt", 32'(rd_cnt), 1);

        check("bus_rules", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sif_initiator.md
Name: sif_initiator

Overview:
- Initiator (master) end of the small SIF bus. It drives xa_wr_s, xa_rd_s, xa_addr and xa_data_wr toward the sif responder, and captures xa_data_rd.
- Commands arrive through a valid/ready queue. Writes are issued back-to-back. Each read is issued alone, and its captured data is returned on a valid/ready response port.
- Used as the bus driver in SIF test harnesses and as the master for SIF-attached blocks.

Parameters:
- AW, 16, address width (xa_addr).
- DW, 16, data width (xa_data_wr / xa_data_rd).
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- RD_LAT, 1, cycles from the xa_rd_s cycle to valid xa_data_rd; range 1..7.

Ports:
- clk  in  1  single clock; everything on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  command address.
- cmd_wdata  in  DW  write data; ignored for reads.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_addr  out  AW  address of the read being returned.
- rsp_rdata  out  DW  captured read data.
- xa_wr_s  out  1  bus write strobe.
- xa_rd_s  out  1  bus read strobe.
- xa_addr  out  AW  bus address.
- xa_data_wr  out  DW  bus write data.
- xa_data_rd  in  DW  bus read data from the responder.
- busy  out  1  FIFO non-empty or state != IDLE.
- wr_cnt  out  16  writes issued; wraps modulo 2^16.
- rd_cnt  out  16  reads issued; wraps modulo 2^16.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0 and the FIFO is empty. cmd_ready=1 from the first cycle after release.
  - Reset mid-operation aborts everything: strobes drop immediately, any pending read or response is discarded, and the FIFO and counters clear.
- Command FIFO:
  - cmd_ready = !full. A push while full is not possible.
  - Push and pop in the same cycle are allowed when not full.
  - FIFO order is preserved.
- Bus outputs are all registered.
  - Strobes are one-cycle pulses.
  - Outside a strobe cycle, xa_addr and xa_data_wr are 0.
  - xa_data_wr is 0 during a read strobe.
  - xa_wr_s and xa_rd_s are never high together.
- State machine (IDLE, RD_WAIT, RSP):
  - IDLE, FIFO non-empty, head is a write:
    - pop the head;
    - next cycle: xa_wr_s=1 with xa_addr and xa_data_wr from the head; wr_cnt+1;
    - stay in IDLE, so consecutive writes produce consecutive strobe cycles.
  - IDLE, FIFO non-empty, head is a read:
    - pop the head and latch its address;
    - next cycle (T): xa_rd_s=1; rd_cnt+1; state=RD_WAIT with wait counter = RD_LAT.
  - RD_WAIT: no bus activity.
    - If counter != 0, decrement it.
    - If counter == 0, capture xa_data_rd into rsp_rdata (sampled at the end of cycle T+RD_LAT) and go to RSP.
  - RSP: rsp_valid=1, with rsp_addr and rsp_rdata held stable until rsp_ready.
    - On the handshake, go to IDLE. The next command issues no earlier than the following cycle.
    - With rsp_ready tied high, a read occupies the bus for RD_LAT+2 cycles.
- No new command is issued while in RD_WAIT or RSP, so at most one read is outstanding.
- The FIFO continues to accept pushes while a read is outstanding.
- Counters wrap 0xFFFF -> 0x0000 silently.

Decomposition:
- Package sif_pkg:
  - sif_state_e enum {IDLE, RD_WAIT, RSP};
  - sif_cmd_t packed struct {wr, addr[AW-1:0], wdata[DW-1:0]};
  - localparams SIF_AW=16, SIF_DW=16.
- Sub-module sif_cmd_fifo:
  - parameterised synchronous FIFO of sif_cmd_t with FIFO_DEPTH entries;
  - ports: push, pop, din, dout, full, empty;
  - resets on the same async active-high rst.
- FSM, bus registers and counters live in sif_initiator.

Test Plan:
1. Reset, then read 0x05DE, 0x0463, 0x1305 against sif (RD_LAT=1), rsp_ready=1.
   - Responses are 0x04DE, 0x04E3, 0x1305 in order, each carrying the matching rsp_addr.
   - Exactly 3 rd strobes, each RD_LAT+2 cycles apart; rd_cnt=3.
2. Push 4 writes (0x0010/0xAAAA, 0x0011/0x5555, 0x0012/0x1234, 0x0013/0xFFFF) on consecutive cycles.
   - 4 consecutive xa_wr_s cycles.
   - wa_addr/wa_data_wr on sif mirror each pair one cycle later.
   - wr_cnt=4; no rsp_valid.
3. Hold rsp_ready=0 for 5 cycles after a read of 0x05DE.
   - rsp_valid stays high and rsp_rdata stays 0x04DE.
   - No bus strobe until the cycle after rsp_ready rises.
   - FIFO fills to 4 and cmd_ready drops.
4. Interleave W 0x0100/0xBEEF, R 0x0463, W 0x0101/0xCAFE.
   - The second write strobe occurs only after the read response handshake.
   - Bus order is W, R, W; the read returns 0x04E3.
5. Assert rst in RD_WAIT.
   - Strobes and outputs go to 0 asynchronously; no rsp_valid is ever produced.
   - FIFO is empty and counters are 0.
   - First post-reset command behaves as in scenario 1.
6. Preload wr_cnt to 0xFFFF via 65535 writes (or a force), then issue 1 write.
   - wr_cnt=0x0000; rd_cnt unchanged.
